// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl: round sequencer for the AES-128 inverse cipher datapath and key schedule.
// Define INV_KEY_CACHE_EN to add the same_key/key_reload cached-key shortcut.
module inv_cipher_ctrl #(
   parameter int NR = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
`ifdef INV_KEY_CACHE_EN
   input  logic       same_key,
   output logic       key_reload,
`endif
   output logic [3:0] round,
   output logic       key_fwd,
   output logic       key_inv,
   output logic       done,
   output logic [3:0] operation
);
   typedef enum logic [3:0] {
      IDLE, KEYEXP, RELOAD, ARK, INV_SHIFT, INV_SUB, SUB_HOLD, KEY_BACK, DEC_ROUND, INV_MIX, DONE
   } state_t;
   localparam logic [3:0] NR4   = 4'(NR);
   localparam logic [3:0] KLAST = 4'(NR - 1);
   state_t     state, next;
   logic [3:0] kcnt;
   logic       reload_req;
`ifdef INV_KEY_CACHE_EN
   assign reload_req = same_key;
   assign key_reload = state == RELOAD;
`else
   assign reload_req = 1'b0;
`endif
   always_comb begin
      next = state;
      case (state)
         IDLE:      next = load ? IDLE : (reload_req ? RELOAD : KEYEXP);
         KEYEXP:    next = (kcnt == KLAST) ? ARK : KEYEXP;
         RELOAD:    next = ARK;
         ARK:       next = (round == 4'd0) ? DONE : (round == NR4) ? INV_SHIFT : INV_MIX;
         INV_MIX:   next = INV_SHIFT;
         INV_SHIFT: next = INV_SUB;
         INV_SUB:   next = SUB_HOLD;
         SUB_HOLD:  next = KEY_BACK;
         KEY_BACK:  next = DEC_ROUND;
         DEC_ROUND: next = ARK;
         DONE:      next = load ? IDLE : DONE;
         default:   next = IDLE;
      endcase
      // load re-asserted mid-decryption aborts back to IDLE
      if (load && state != IDLE && state != DONE)
         next = IDLE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         round <= 4'd0;
         kcnt  <= 4'd0;
      end else begin
         state <= next;
         kcnt  <= (state == KEYEXP && next == KEYEXP) ? kcnt + 4'd1 : 4'd0;
         round <= (next == IDLE) ? 4'd0 :
                  (next == ARK && (state == KEYEXP || state == RELOAD)) ? NR4 :
                  (state == DEC_ROUND && next == ARK && round != 4'd0) ? round - 4'd1 : round;
      end
   end
   assign key_fwd   = state == KEYEXP;
   assign key_inv   = state == KEY_BACK;
   assign done      = state == DONE;
   assign operation = {state == INV_MIX, state == INV_SHIFT, state == INV_SUB || state == SUB_HOLD, state == ARK};
endmodule

// File: tb/tb_inv_cipher_ctrl.sv
// tb_inv_cipher_ctrl: scoreboard bench; a round-level reference model predicts every output event.
module tb_inv_cipher_ctrl;
   localparam int NR = 10;
   typedef struct packed {
      int unsigned cyc;
      logic [3:0]  rnd;
      logic        kf, ki, kr, dn;
      logic [3:0]  op;
   } ev_t;
   logic        clk = 1'b0, reset = 1'b1, load = 1'b1;
   logic [3:0]  round, operation;
   logic        key_fwd, key_inv, done, key_reload, done_q = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0, errors = 0;
   ev_t         exp_q[$], ev[$], got, e;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
`ifdef INV_KEY_CACHE_EN
   logic same_key = 1'b0;
   inv_cipher_ctrl #(.NR(NR)) dut (.clk(clk), .reset(reset), .load(load), .same_key(same_key),
      .key_reload(key_reload), .round(round), .key_fwd(key_fwd), .key_inv(key_inv), .done(done),
      .operation(operation));
`else
   assign key_reload = 1'b0;
   inv_cipher_ctrl #(.NR(NR)) dut (.clk(clk), .reset(reset), .load(load), .round(round),
      .key_fwd(key_fwd), .key_inv(key_inv), .done(done), .operation(operation));
`endif
   function automatic ev_t mk(int unsigned c, int r, bit kf, bit ki, bit kr, bit dn, logic [3:0] op);
      ev_t x;
      x.cyc = c; x.rnd = 4'(r); x.kf = kf; x.ki = ki; x.kr = kr; x.dn = dn; x.op = op;
      return x;
   endfunction
   // Expected visible events of one decryption whose first cycle is s
   task automatic build(input int unsigned s, input bit rl);
      int unsigned t = s;
      ev.delete();
      if (rl) begin ev.push_back(mk(t, 0, 0, 0, 1, 0, 4'h0)); t++; end
      else for (int k = 0; k < NR; k++) begin ev.push_back(mk(t, 0, 1, 0, 0, 0, 4'h0)); t++; end
      for (int r = NR; r >= 0; r--) begin
         ev.push_back(mk(t, r, 0, 0, 0, 0, 4'h1)); t++;
         if (r == 0) break;
         if (r != NR) begin ev.push_back(mk(t, r, 0, 0, 0, 0, 4'h8)); t++; end
         ev.push_back(mk(t, r, 0, 0, 0, 0, 4'h4)); t++;
         ev.push_back(mk(t, r, 0, 0, 0, 0, 4'h2)); t++;
         ev.push_back(mk(t, r, 0, 0, 0, 0, 4'h2)); t++;
         ev.push_back(mk(t, r, 0, 1, 0, 0, 4'h0)); t++;
         t++;
      end
      ev.push_back(mk(t, 0, 0, 0, 0, 1, 4'h0));
   endtask
   function automatic int find(logic [3:0] op, int r);
      for (int i = 0; i < ev.size(); i++)
         if (ev[i].op == op && ev[i].rnd == 4'(r)) return i;
      return ev.size() - 1;
   endfunction
   task automatic tick();
      @(posedge clk); #1;
   endtask
   task automatic wait_cyc(input int unsigned c);
      while (cyc < c) tick();
   endtask
   task automatic chk(input string nm, input int g, input int x);
      checks++;
      if (g !== x) begin errors++; $display("FAIL %s got=%0d exp=%0d", nm, g, x); end
   endtask
   task automatic idle_chk(input string nm);
      chk({nm, "_round"}, round, 0);
      chk({nm, "_op"}, operation, 0);
      chk({nm, "_pulses"}, {key_fwd, key_inv, key_reload, done}, 0);
   endtask
   // kind: 0 run to DONE and hold, 1 abort in round-4 InvMixColumns, 2 abort at a random event
   task automatic run(input bit rl, input int kind, input int hold);
      int n;
      load = 1'b1;
      repeat (2) tick();
`ifdef INV_KEY_CACHE_EN
      same_key = rl;
`endif
      load = 1'b0;
      build(cyc + 1, rl);
      n = (kind == 1) ? find(4'h8, 4) + 1 : (kind == 2) ? $urandom_range(1, ev.size()) : ev.size();
      for (int i = 0; i < n; i++) exp_q.push_back(ev[i]);
      wait_cyc(ev[n-1].cyc);
      if (kind != 0) begin
         load = 1'b1;
         @(posedge clk); @(negedge clk);
         idle_chk("abort");
      end else begin
         repeat (hold) tick();
         @(negedge clk);
         chk("done_hold", done, 1);
         @(posedge clk); #1 load = 1'b1;
         @(posedge clk); @(negedge clk);
         chk("done_release", done, 0);
      end
`ifdef INV_KEY_CACHE_EN
      same_key = 1'b0;
`endif
      chk("queue_drained", exp_q.size(), 0);
   endtask
   // Monitor: every cycle checks exclusivity; every visible event is matched against the scoreboard
   initial forever begin
      @(negedge clk);
      checks++;
      if (!$onehot0({key_fwd, key_inv, key_reload, |operation}) || !$onehot0(operation)) begin
         errors++;
         $display("FAIL exclusive cyc=%0d kf=%b ki=%b kr=%b op=%b", cyc, key_fwd, key_inv, key_reload, operation);
      end
      if (key_fwd || key_inv || key_reload || operation != 4'h0 || (done && !done_q)) begin
         checks++;
         got = mk(cyc, int'(round), key_fwd, key_inv, key_reload, done, operation);
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d rnd=%0d kf=%b ki=%b kr=%b dn=%b op=%b",
               got.cyc, got.rnd, got.kf, got.ki, got.kr, got.dn, got.op);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL event got cyc=%0d rnd=%0d kf=%b ki=%b kr=%b dn=%b op=%b exp cyc=%0d rnd=%0d kf=%b ki=%b kr=%b dn=%b op=%b",
                  got.cyc, got.rnd, got.kf, got.ki, got.kr, got.dn, got.op,
                  e.cyc, e.rnd, e.kf, e.ki, e.kr, e.dn, e.op);
            end
         end
      end
      done_q = done;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
   initial begin
      int idx;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      idle_chk("post_reset");
      repeat (3) tick();
      load = 1'b0;
      build(cyc + 1, 1'b0);
      idx = find(4'h2, 6);
      for (int i = 0; i <= idx; i++) exp_q.push_back(ev[i]);
      wait_cyc(ev[idx].cyc);
      reset = 1'b1;
      load = 1'b1;
      @(posedge clk); @(negedge clk);
      idle_chk("mid_reset");
      @(posedge clk); #1 reset = 1'b0;
      run(1'b0, 0, 200);
      run(1'b0, 1, 0);
      run(1'b0, 0, 3);
`ifdef INV_KEY_CACHE_EN
      run(1'b1, 0, 5);
      run(1'b0, 0, 5);
`endif
      for (int k = 0; k < 12; k++) begin
`ifdef INV_KEY_CACHE_EN
         run(1'($urandom_range(0, 1)), 2 * $urandom_range(0, 1), $urandom_range(1, 20));
`else
         run(1'b0, 2 * $urandom_range(0, 1), $urandom_range(1, 20));
`endif
      end
      repeat (5) tick();
      chk("final_queue", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
